irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
Interrupt source for the fetch stage. It collects external interrupt lines and latches them as pending. It raises alert to IF, which saves the return PC into PCI and sets interrupt_mask. IF answers with its interrupt (taken) pulse and later with pci_take (return). The block exposes the active IRQ id and handler vector to the next-PC logic, and a small config/status register port to the memory controller.

Parameters:
NUM_IRQ, 8, number of interrupt lines (1..16)
VEC_BASE, 32'h0000_0100, handler vector for IRQ 0
VEC_STRIDE, 32'h0000_0010, vector spacing between IRQ ids

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
irq_in  input  NUM_IRQ  asynchronous interrupt request lines, rising-edge sensitive
interrupt_mask  input  1  from IF; high while an interrupt is in service
taken  input  1  from IF interrupt output; 1-cycle pulse when the handler fetch begins
pci_take  input  1  from IF; 1-cycle pulse on return from interrupt
alert  output  1  to IF; request interrupt entry
irq_id  output  4  id of the active or alerted IRQ
irq_vector  output  32  handler PC = VEC_BASE + irq_id*VEC_STRIDE
cfg_we  input  1  config write strobe
cfg_addr  input  2  config register select
cfg_wdata  input  32  config write data
cfg_rdata  output  32  config read data, combinational on cfg_addr

Behaviour:
- Reset: all outputs 0, state IDLE. Pending, enable and global-enable registers are 0. Synchronizer flops are 0.
- Reset is asynchronous and may arrive mid-operation, including in ALERT or SERVICE. It returns the block to IDLE immediately, alert=0, pending cleared.
- Input path: each irq_in bit passes through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync3).
  - An edge sets pending[i] 3 cycles after the pin rises.
  - A level held high produces one edge only.
- Pending clear sources: taken (clears pending[irq_id]) and cfg write-1-to-clear.
  - A set and a clear of the same bit in the same cycle: set wins.
- Eligible = pending & enable, qualified by gie=1 and interrupt_mask=0.
- Priority: lowest set index wins. Fixed priority, no rotation.
- FSM states and transitions:
  - IDLE: alert=0. If eligible is nonzero, latch irq_id = winning index and go to ALERT next cycle.
  - ALERT: alert=1, held until taken.
    - On taken: clear pending[irq_id], deassert alert on the next edge, go to SERVICE.
    - irq_id is frozen in ALERT. A higher-priority arrival does not retarget.
    - Clearing enable or gie in ALERT does not withdraw alert; the request is committed.
  - SERVICE: alert=0, irq_id held. On pci_take go to IDLE.
    - No nesting: new edges only accumulate in pending.
- Ignored inputs: taken outside ALERT, and pci_take outside SERVICE.
- Back-to-back: pci_take in cycle N with another eligible pending bit gives alert=1 at cycle N+2 (IDLE for one cycle). interrupt_mask must also be low by then.
- irq_vector arithmetic is 32-bit, with wrap-around permitted. irq_id is zero-extended.
- Register map (cfg_addr):
  - 0: enable[NUM_IRQ-1:0], read/write.
  - 1: pending. Read returns pending; write is W1C.
  - 2: status, read-only: {26'b0, state[1:0], irq_id[3:0]}.
  - 3: gie, bit 0, read/write.
  - Unused bits read 0. A write takes effect at the next edge.

Decomposition:
- Package irq_pkg holds:
  - state enum {IDLE=2'd0, ALERT=2'd1, SERVICE=2'd2}
  - cfg address constants CFG_EN=0, CFG_PEND=1, CFG_STAT=2, CFG_GIE=3
  - MAX_IRQ=16
- One sub-module: irq_sync_edge, the per-line 2-flop synchronizer plus edge detect with rst_n. Instantiate it NUM_IRQ times via generate.
- Priority encoder, FSM and register file stay in irq_ctrl.

Test Plan:
- Basic entry:
  - Stimulus: gie=1, enable=8'h08; pulse irq_in[3] at cycle 0.
  - Response: pending=8'h08 at cycle 3, alert=1 at cycle 4, irq_id=3, irq_vector=32'h130.
  - Then taken at cycle 6 gives alert=0 and pending=0 at cycle 7, status state=SERVICE.
- Priority and no nesting:
  - Stimulus: enable=8'hFF; edges on lines 5 and 2 in the same cycle.
  - Response: irq_id=2. After taken, pending=8'h20 and alert stays 0 through SERVICE.
  - pci_take then gives alert=1 two cycles later with irq_id=5.
- Gating:
  - Stimulus: pending edge on line 1 with enable=0, or gie=0, or interrupt_mask=1.
  - Response: alert remains 0 and pending=8'h02.
  - Writing enable=8'h02 (with gie=1, mask=0) gives alert=1 two cycles later.
- W1C and set-wins race:
  - Stimulus: write 8'h01 to CFG_PEND in the same cycle an edge on line 0 reaches pending.
  - Response: pending[0]=1.
  - A write of 8'h01 with no edge gives pending[0]=0.
- Committed alert plus spurious acks:
  - Stimulus: clear gie during ALERT.
  - Response: alert stays 1 until taken.
  - pci_take in IDLE and taken in SERVICE leave the state unchanged.
- Reset mid-service:
  - Stimulus: assert rst_n=0 in SERVICE with pending=8'h10.
  - Response: immediate alert=0, state=IDLE, pending=0, enable=0, cfg_rdata(addr 2)=0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
// State encoding, config register addresses and line limit.
package irq_pkg;

  localparam int MAX_IRQ = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALERT   = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] CFG_EN   = 2'd0;
  localparam logic [1:0] CFG_PEND = 2'd1;
  localparam logic [1:0] CFG_STAT = 2'd2;
  localparam logic [1:0] CFG_GIE  = 2'd3;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: 2-flop synchronizer plus rising-edge detect.
// Ports: clk, rst_n, d (async line), rise (1-cycle edge pulse).
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding IF: pending/enable/gie, fixed priority, alert FSM.
// Ports: irq_in, IF handshake (interrupt_mask/taken/pci_take/alert), id/vector, cfg port.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               interrupt_mask,
  input  logic               taken,
  input  logic               pci_take,
  output logic               alert,
  output logic [3:0]         irq_id,
  output logic [31:0]        irq_vector,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata
);

  irq_state_e         state_q, state_d;
  logic [3:0]         id_q, id_d, win_id;
  logic [NUM_IRQ-1:0] rise, pend_q, pend_d;
  logic [NUM_IRQ-1:0] en_q, elig, clr;
  logic               gie_q, any, ack;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:NUM_IRQ];

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_sync_edge u_se (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (irq_in[g]),
      .rise  (rise[g])
    );
  end

  assign elig = (gie_q && !interrupt_mask) ? (pend_q & en_q) : '0;
  assign any  = |elig;
  assign ack  = taken && (state_q == ALERT);

  // Descending scan so the lowest set index is the last write.
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (elig[i]) win_id = 4'(i);
  end

  // New edges OR in after clears, so a same-cycle set wins.
  always_comb begin
    clr = '0;
    if (cfg_we && cfg_addr == CFG_PEND)
      clr = cfg_wdata[NUM_IRQ-1:0];
    if (ack)
      for (int i = 0; i < NUM_IRQ; i++)
        if (id_q == 4'(i)) clr[i] = 1'b1;
    pend_d = (pend_q & ~clr) | rise;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = ALERT;
          id_d    = win_id;
        end
      end
      ALERT:   if (taken) state_d = SERVICE;
      SERVICE: if (pci_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      gie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      if (cfg_we && cfg_addr == CFG_EN)
        en_q <= cfg_wdata[NUM_IRQ-1:0];
      if (cfg_we && cfg_addr == CFG_GIE)
        gie_q <= cfg_wdata[0];
    end
  end

  assign alert      = (state_q == ALERT);
  assign irq_id     = id_q;
  assign irq_vector = VEC_BASE + 32'(id_q) * VEC_STRIDE;

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      CFG_EN:   cfg_rdata = 32'(en_q);
      CFG_PEND: cfg_rdata = 32'(pend_q);
      CFG_STAT: cfg_rdata = {26'b0, state_q, id_q};
      CFG_GIE:  cfg_rdata = {31'b0, gie_q};
      default:  cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl.
// Hand-computed expectations, one checking task, one summary line.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_in;
  logic        interrupt_mask, taken, pci_take;
  logic        alert;
  logic [3:0]  irq_id;
  logic [31:0] irq_vector;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;

  int errs = 0;
  int checks = 0;

  irq_ctrl #(
    .NUM_IRQ    (8),
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0010)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_in         (irq_in),
    .interrupt_mask (interrupt_mask),
    .taken          (taken),
    .pci_take       (pci_take),
    .alert          (alert),
    .irq_id         (irq_id),
    .irq_vector     (irq_vector),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    cfg_addr = a;
    #1;
    v = cfg_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic pulse_taken();
    taken = 1'b1;
    tick();
    taken = 1'b0;
  endtask

  task automatic pulse_ret();
    pci_take = 1'b1;
    tick();
    pci_take = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    rst_n          = 1'b0;
    irq_in         = '0;
    interrupt_mask = 1'b0;
    taken          = 1'b0;
    pci_take       = 1'b0;
    cfg_we         = 1'b0;
    cfg_addr       = '0;
    cfg_wdata      = '0;
    #12;
    chk("rst_alert", 32'(alert), 32'h0);
    chk("rst_id", 32'(irq_id), 32'h0);
    rd(CFG_EN, v);   chk("rst_en", v, 32'h0);
    rd(CFG_PEND, v); chk("rst_pend", v, 32'h0);
    rd(CFG_STAT, v); chk("rst_stat", v, 32'h0);
    rd(CFG_GIE, v);  chk("rst_gie", v, 32'h0);
    rst_n = 1'b1;
    ticks(2);

    // basic entry on line 3
    wr(CFG_GIE, 32'h1);
    wr(CFG_EN, 32'h08);
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    ticks(2);
    rd(CFG_PEND, v); chk("b_pend3", v, 32'h08);
    chk("b_alert3", 32'(alert), 32'h0);
    tick();
    chk("b_alert4", 32'(alert), 32'h1);
    chk("b_id", 32'(irq_id), 32'h3);
    chk("b_vec", irq_vector, 32'h130);
    ticks(2);
    chk("b_hold", 32'(alert), 32'h1);
    pulse_taken();
    chk("b_alert7", 32'(alert), 32'h0);
    rd(CFG_PEND, v); chk("b_pend7", v, 32'h0);
    rd(CFG_STAT, v); chk("b_stat_svc", v, 32'h23);
    pulse_ret();
    rd(CFG_STAT, v); chk("b_stat_idle", v, 32'h03);

    // priority and no nesting
    wr(CFG_EN, 32'hFF);
    irq_in = 8'h24;
    tick();
    irq_in = 8'h00;
    ticks(3);
    chk("p_alert", 32'(alert), 32'h1);
    chk("p_id2", 32'(irq_id), 32'h2);
    chk("p_vec2", irq_vector, 32'h120);
    pulse_taken();
    rd(CFG_PEND, v); chk("p_pend", v, 32'h20);
    ticks(3);
    chk("p_nonest", 32'(alert), 32'h0);
    rd(CFG_STAT, v); chk("p_stat_svc", v, 32'h22);
    pulse_ret();
    chk("p_gap", 32'(alert), 32'h0);
    tick();
    chk("p_b2b", 32'(alert), 32'h1);
    chk("p_id5", 32'(irq_id), 32'h5);
    chk("p_vec5", irq_vector, 32'h150);
    pulse_taken();
    pulse_ret();

    // gating on line 1
    wr(CFG_EN, 32'h00);
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    ticks(4);
    chk("g_en0", 32'(alert), 32'h0);
    rd(CFG_PEND, v); chk("g_pend", v, 32'h02);
    wr(CFG_GIE, 32'h0);
    wr(CFG_EN, 32'h02);
    ticks(2);
    chk("g_gie0", 32'(alert), 32'h0);
    interrupt_mask = 1'b1;
    wr(CFG_GIE, 32'h1);
    ticks(2);
    chk("g_mask", 32'(alert), 32'h0);
    wr(CFG_EN, 32'h00);
    interrupt_mask = 1'b0;
    tick();
    wr(CFG_EN, 32'h02);
    chk("g_wr_n1", 32'(alert), 32'h0);
    tick();
    chk("g_wr_n2", 32'(alert), 32'h1);
    chk("g_id1", 32'(irq_id), 32'h1);

    // committed alert and spurious acks
    wr(CFG_GIE, 32'h0);
    wr(CFG_EN, 32'h00);
    ticks(2);
    chk("c_commit", 32'(alert), 32'h1);
    pulse_taken();
    rd(CFG_STAT, v); chk("c_svc", v, 32'h21);
    rd(CFG_PEND, v); chk("c_pend", v, 32'h0);
    pulse_taken();
    rd(CFG_STAT, v); chk("c_spur_tk", v, 32'h21);
    pulse_ret();
    rd(CFG_STAT, v); chk("c_ret", v, 32'h01);
    pulse_ret();
    rd(CFG_STAT, v); chk("c_spur_ret", v, 32'h01);

    // W1C versus same-cycle set on line 0
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    wr(CFG_PEND, 32'h01);
    rd(CFG_PEND, v); chk("w_setwins", v, 32'h01);
    wr(CFG_PEND, 32'h01);
    rd(CFG_PEND, v); chk("w_clear", v, 32'h00);

    // reset mid-service with pending line 4
    wr(CFG_GIE, 32'h1);
    wr(CFG_EN, 32'hFF);
    irq_in = 8'h11;
    tick();
    irq_in = 8'h00;
    ticks(3);
    chk("r_id0", 32'(irq_id), 32'h0);
    pulse_taken();
    rd(CFG_PEND, v); chk("r_pend", v, 32'h10);
    rd(CFG_STAT, v); chk("r_svc", v, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_alert", 32'(alert), 32'h0);
    rd(CFG_STAT, v); chk("r_stat", v, 32'h0);
    rd(CFG_PEND, v); chk("r_pend0", v, 32'h0);
    rd(CFG_EN, v);   chk("r_en0", v, 32'h0);
    rd(CFG_GIE, v);  chk("r_gie0", v, 32'h0);
    rst_n = 1'b1;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
